// File: rtl/classifier_param_collector_pkg.sv
// classifier_param_collector_pkg: shared face-detection constants and FSM encoding.
package classifier_param_collector_pkg;
    localparam int DEF_ADDR_WIDTH               = 10;
    localparam int DEF_DATA_WIDTH_12            = 12;
    localparam int DEF_NUM_CLASSIFIERS_STAGE    = 10;
    localparam int DEF_NUM_PARAM_PER_CLASSIFIER = 19;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;
endpackage

// File: rtl/classifier_param_collector_if.sv
// classifier_param_collector_if: stage-database input stream and classifier record output.
interface classifier_param_collector_if
    import classifier_param_collector_pkg::*;
#(
    parameter int ADDR_WIDTH               = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH_12            = DEF_DATA_WIDTH_12,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER
);
    logic                                        i_enable;
    logic                                        i_valid;
    logic [DATA_WIDTH_12-1:0]                    i_data;
    logic                                        o_ready;
    logic                                        o_classifier_valid;
    logic                                        i_classifier_ready;
    logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0] o_classifier_params;
    logic [ADDR_WIDTH-1:0]                       o_tree_index;
    logic                                        o_end_stage;
    modport slave (
        input  i_enable, i_valid, i_data, i_classifier_ready,
        output o_ready, o_classifier_valid, o_classifier_params, o_tree_index, o_end_stage
    );
    modport master (
        output i_enable, i_valid, i_data, i_classifier_ready,
        input  o_ready, o_classifier_valid, o_classifier_params, o_tree_index, o_end_stage
    );
endinterface

// File: rtl/classifier_param_collector_counter.sv
// classifier_param_collector_counter: wrapping 0..max_size-1 counter with clear and end_count flag.
module classifier_param_collector_counter #(
    parameter int WIDTH    = 10,
    parameter int MAX_SIZE = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             end_count_o
);
    logic [WIDTH-1:0] count_q;
    assign count_o     = count_q;
    assign end_count_o = count_q == WIDTH'(MAX_SIZE - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else if (clr_i) count_q <= '0;
        else if (inc_i) count_q <= end_count_o ? '0 : count_q + 1'b1;
    end
endmodule

// File: rtl/classifier_param_collector.sv
// classifier_param_collector: gathers stage-database words into per-classifier records
// and hands them downstream one at a time, pulsing o_end_stage after the last of a stage.
module classifier_param_collector
    import classifier_param_collector_pkg::*;
#(
    parameter int ADDR_WIDTH               = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH_12            = DEF_DATA_WIDTH_12,
    parameter int NUM_CLASSIFIERS_STAGE    = DEF_NUM_CLASSIFIERS_STAGE,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER
) (
    input logic                          clk_fpga,
    input logic                          reset_fpga,
    classifier_param_collector_if.slave  bus
);
    state_t                   state_q;
    logic                     valid_q, end_stage_q;
    logic [DATA_WIDTH_12-1:0] params_q [NUM_PARAM_PER_CLASSIFIER];
    logic [ADDR_WIDTH-1:0]    param_cnt, tree_idx;
    logic                     param_end, tree_end, accept, handshake, abort;
    assign bus.o_ready            = state_q == COLLECT && bus.i_enable;
    assign bus.o_classifier_valid = valid_q;
    assign bus.o_end_stage        = end_stage_q;
    assign bus.o_tree_index       = tree_idx;
    assign accept    = bus.o_ready && bus.i_valid;
    assign handshake = state_q == HOLD && bus.i_classifier_ready;
    assign abort     = state_q == COLLECT && !bus.i_enable;
    for (genvar k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) begin : g_flat
        assign bus.o_classifier_params[k*DATA_WIDTH_12 +: DATA_WIDTH_12] = params_q[k];
    end
    classifier_param_collector_counter #(.WIDTH(ADDR_WIDTH), .MAX_SIZE(NUM_PARAM_PER_CLASSIFIER)) u_param_cnt (
        .clk(clk_fpga), .rst_n(reset_fpga), .clr_i(abort), .inc_i(accept),
        .count_o(param_cnt), .end_count_o(param_end)
    );
    classifier_param_collector_counter #(.WIDTH(ADDR_WIDTH), .MAX_SIZE(NUM_CLASSIFIERS_STAGE)) u_tree_cnt (
        .clk(clk_fpga), .rst_n(reset_fpga), .clr_i(abort), .inc_i(handshake),
        .count_o(tree_idx), .end_count_o(tree_end)
    );
    // A disabled HOLD keeps its record; the abort takes effect in COLLECT after the handshake.
    always_ff @(posedge clk_fpga or negedge reset_fpga) begin
        if (!reset_fpga) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            end_stage_q <= 1'b0;
            for (int k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) params_q[k] <= '0;
        end else begin
            end_stage_q <= handshake && tree_end;
            for (int k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++)
                if (accept && param_cnt == ADDR_WIDTH'(k)) params_q[k] <= bus.i_data;
            case (state_q)
                IDLE:    state_q <= bus.i_enable ? COLLECT : IDLE;
                COLLECT: begin
                    if (abort) state_q <= IDLE;
                    else if (accept && param_end) begin
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state_q <= tree_end ? IDLE : COLLECT;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_classifier_param_collector.sv
// tb_classifier_param_collector: randomized stream with a record-level reference model and scoreboard.
module tb_classifier_param_collector;
    localparam int NP = 19;
    localparam int DW = 12;
    localparam int NC = 10;
    typedef struct {
        logic [NP*DW-1:0] p;
        int               idx;
    } rec_t;
    logic clk = 1'b0;
    logic reset_fpga = 1'b0;
    classifier_param_collector_if bus ();
    classifier_param_collector dut (.clk_fpga(clk), .reset_fpga(reset_fpga), .bus(bus));
    always #5 clk = ~clk;
    rec_t             exp_q[$];
    logic [DW-1:0]    cur[$];
    int               model_idx = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    bit               exp_end = 0;
    bit               rdy_rand = 0;
    int               rdy_block = 0;
    bit               gaps = 0;
    function automatic void chk(string name, logic [NP*DW-1:0] act, logic [NP*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    // Reference model: every NP accepted words form one record; records cycle through NC indices.
    function automatic void model_accept(logic [DW-1:0] w);
        rec_t r;
        cur.push_back(w);
        if (cur.size() == NP) begin
            for (int k = 0; k < NP; k++) r.p[k*DW +: DW] = cur[k];
            r.idx = model_idx;
            exp_q.push_back(r);
            model_idx = (model_idx + 1) % NC;
            cur.delete();
        end
    endfunction
    task automatic send(logic [DW-1:0] w);
        bit acc = 0;
        int t = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        while (!acc) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            if (++t > 300) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        if (acc) model_accept(w);
        bus.i_valid = 1'b0;
        bus.i_data  = DW'($urandom);
        if (gaps && $urandom_range(99) < 30) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send_rec();
        for (int k = 0; k < NP; k++) send(DW'($urandom));
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.i_classifier_ready = rdy_block > 0 ? 1'b0 : (rdy_rand ? 1'($urandom) : 1'b1);
            if (rdy_block > 0) rdy_block--;
        end
    end
    always @(negedge clk) begin
        if (!reset_fpga) exp_end = 0;
        else begin
            if (exp_end || bus.o_end_stage) chk("end_stage", bus.o_end_stage, exp_end);
            if (bus.o_end_stage) chk("idle_after_end", bus.o_ready, 0);
            exp_end = 0;
            if (bus.o_classifier_valid) begin
                chk("hold_ready", bus.o_ready, 0);
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    chk("params", bus.o_classifier_params, exp_q[0].p);
                    chk("tree_index", bus.o_tree_index, exp_q[0].idx);
                    if (bus.i_classifier_ready) begin
                        exp_end = exp_q[0].idx == NC - 1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end
    initial begin
        int t;
        bus.i_enable = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.i_classifier_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_valid", bus.o_classifier_valid, 0);
        chk("rst_end", bus.o_end_stage, 0);
        chk("rst_params", bus.o_classifier_params, 0);
        chk("rst_index", bus.o_tree_index, 0);
        reset_fpga = 1'b1;
        bus.i_enable = 1'b1;
        for (int k = 0; k < NP; k++) send(DW'(k + 1));
        chk("first_valid_latency", bus.o_classifier_valid, 1);
        chk("first_index", bus.o_tree_index, 0);
        repeat (NC - 1) send_rec();
        rdy_rand = 1;
        gaps = 1;
        repeat (5) send_rec();
        for (int k = 0; k < NP - 1; k++) send(DW'($urandom));
        gaps = 0;
        rdy_block = 7;
        send(DW'($urandom));
        gaps = 1;
        repeat (6) send_rec();
        for (int k = 0; k < 7; k++) send(DW'($urandom));
        bus.i_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_index", bus.o_tree_index, 0);
        cur.delete();
        model_idx = 0;
        bus.i_enable = 1'b1;
        repeat (2) send_rec();
        for (int k = 0; k < NP - 1; k++) send(DW'($urandom));
        gaps = 0;
        rdy_block = 30;
        send(DW'($urandom));
        repeat (2) @(posedge clk);
        #2;
        reset_fpga = 1'b0;
        #1;
        chk("arst_ready", bus.o_ready, 0);
        chk("arst_valid", bus.o_classifier_valid, 0);
        chk("arst_end", bus.o_end_stage, 0);
        chk("arst_params", bus.o_classifier_params, 0);
        chk("arst_index", bus.o_tree_index, 0);
        exp_q.delete();
        cur.delete();
        model_idx = 0;
        rdy_block = 0;
        @(negedge clk);
        reset_fpga = 1'b1;
        gaps = 1;
        repeat (5) send_rec();
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
